// File: rtl/adc733_wrap.sv
// adc733_wrap: receive-side wrapper for an AD73360-class six-channel serial ADC codec.
//
// The codec's SCLK strobes a small front end that deserialises SDOFS-framed SDO words into a
// holding register and flips a word-ready toggle. The toggle crosses into clk through a 2-FF
// synchroniser. Each toggle edge delivers the held word, tagged with a channel index.
//
// Ports:
//   clk        system clock (the only clock for the delivery side)
//   rst_l      asynchronous active-low reset for both the clk and SCLK logic
//   SCLK       codec serial clock, used only as the capture strobe
//   SDOFS      codec output frame sync (one SCLK period high before each word)
//   SDO        codec serial data, MSB first
//   SDIFS, SDI codec input framing/data, held 0 (data-only mode)
//   SE         codec serial-port enable, set by the first SYNC and held until reset
//   SYNC       clk-domain pulse; enables the port and realigns the channel index to 0
//   ch_data    last received sample
//   ch_idx     channel index of ch_data
//   ch_valid   one-clk pulse when ch_data/ch_idx update
//   frame_done one-clk pulse with ch_valid when ch_idx is the last channel
module adc733_wrap #(
    parameter int unsigned N_CH   = 6,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              SCLK,
    input  logic              SDOFS,
    input  logic              SDO,
    output logic              SDIFS,
    output logic              SDI,
    output logic              SE,
    input  logic              SYNC,
    output logic [DATA_W-1:0] ch_data,
    output logic [2:0]        ch_idx,
    output logic              ch_valid,
    output logic              frame_done
);

    localparam int unsigned     CntW    = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
    localparam logic [2:0]      LastCh  = 3'(N_CH - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;

    // ---------------- SCLK-strobed front end ----------------
    logic [0:0]        state_q;
    logic [CntW-1:0]   cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] hold_q;
    logic              tog_q;
    logic [DATA_W-1:0] shift_next;

    assign shift_next = {shift_q[DATA_W-2:0], SDO};

    always_ff @(posedge SCLK or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
            tog_q   <= 1'b0;
        end else if (state_q == StIdle) begin
            // SDO on the frame-sync edge itself carries no data.
            if (SDOFS) begin
                state_q <= StShift;
                cnt_q   <= '0;
            end
        end else begin
            if (SDOFS) begin
                // A new frame sync drops the partial word; data restarts next edge.
                cnt_q <= '0;
            end else begin
                shift_q <= shift_next;
                if (cnt_q == LastBit) begin
                    hold_q  <= shift_next;
                    tog_q   <= ~tog_q;
                    state_q <= StIdle;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    // ---------------- clk-domain delivery ----------------
    // hold_q is stable for >= 17 SCLK periods after the toggle flips, far longer than the
    // synchroniser latency, so it is sampled directly when the toggle edge arrives.
    logic [2:0] tog_sync_q;
    logic [2:0] next_idx_q;
    logic       word_rdy;

    assign word_rdy = tog_sync_q[1] ^ tog_sync_q[2];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tog_sync_q <= '0;
            next_idx_q <= '0;
            SE         <= 1'b0;
            ch_data    <= '0;
            ch_idx     <= '0;
            ch_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            tog_sync_q <= {tog_sync_q[1:0], tog_q};
            SE         <= SE | SYNC;
            ch_valid   <= word_rdy;
            frame_done <= word_rdy && (next_idx_q == LastCh);
            if (word_rdy) begin
                ch_data <= hold_q;
                ch_idx  <= next_idx_q;
            end
            // SYNC wins over the post-delivery increment.
            if (SYNC) begin
                next_idx_q <= '0;
            end else if (word_rdy) begin
                next_idx_q <= (next_idx_q == LastCh) ? 3'd0 : next_idx_q + 3'd1;
            end
        end
    end

    assign SDIFS = 1'b0;
    assign SDI   = 1'b0;

endmodule

// File: tb/tb_adc733_wrap.sv
`timescale 1ns / 1ps
module tb_adc733_wrap;

    localparam int N_CH = 6;

    logic        clk;
    logic        rst_l;
    logic        SCLK;
    logic        SDOFS;
    logic        SDO;
    logic        SDIFS;
    logic        SDI;
    logic        SE;
    logic        SYNC;
    logic [15:0] ch_data;
    logic [2:0]  ch_idx;
    logic        ch_valid;
    logic        frame_done;

    adc733_wrap #(
        .N_CH  (6),
        .DATA_W(16)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .SCLK      (SCLK),
        .SDOFS     (SDOFS),
        .SDO       (SDO),
        .SDIFS     (SDIFS),
        .SDI       (SDI),
        .SE        (SE),
        .SYNC      (SYNC),
        .ch_data   (ch_data),
        .ch_idx    (ch_idx),
        .ch_valid  (ch_valid),
        .frame_done(frame_done)
    );

    // clk posedges fall on even ns; SCLK rising edges are placed on odd ns.
    initial clk = 1'b0;
    always #42 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   clk_n = 0;
    logic sync_seen = 1'b0;
    int   model_next = 0;
    logic se_model = 1'b0;
    int   last_bit0_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Posedge bookkeeping: count edges and remember what SYNC the DUT just sampled.
    initial forever begin
        @(posedge clk);
        sync_seen = SYNC;
        clk_n++;
    end

    // Reference model and per-cycle compare.
    initial forever begin
        exp_t e;
        int   lat;
        @(negedge clk);
        chk("SDI", 32'(SDI), 0);
        chk("SDIFS", 32'(SDIFS), 0);
        if (!rst_l) begin
            model_next = 0;
            se_model   = 1'b0;
            chk("rst_SE", 32'(SE), 0);
            chk("rst_ch_valid", 32'(ch_valid), 0);
            chk("rst_frame_done", 32'(frame_done), 0);
            chk("rst_ch_data", 32'(ch_data), 0);
            chk("rst_ch_idx", 32'(ch_idx), 0);
        end else begin
            if (sync_seen) se_model = 1'b1;
            chk("SE", 32'(SE), 32'(se_model));
            if (ch_valid) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ch_valid: got data %0h idx %0d, expected none",
                             ch_data, ch_idx);
                end else begin
                    e   = q.pop_front();
                    lat = clk_n - e.cnt;
                    chk("ch_data", 32'(ch_data), 32'(e.data));
                    chk("ch_idx", 32'(ch_idx), 32'(model_next));
                    chk("frame_done", 32'(frame_done), 32'(model_next == N_CH - 1));
                    n_cmp++;
                    if (lat < 3 || lat > 4) begin
                        n_bad++;
                        $display("FAIL latency: got %0d clk edges, expected 3..4", lat);
                    end
                    model_next = (model_next + 1) % N_CH;
                end
            end else begin
                chk("frame_done_idle", 32'(frame_done), 0);
            end
            if (sync_seen) model_next = 0;
        end
    end

    // One SCLK period: drive while low, rising edge 61 ns later.
    task automatic sclk_edge(input logic fs, input logic d);
        SDOFS = fs;
        SDO   = d;
        #61 SCLK = 1'b1;
        #61 SCLK = 1'b0;
    endtask

    // abort_at>0: send that many junk bits then re-sync. stop_at>0: quit after that many bits.
    task automatic send_word(input logic [15:0] w, input int abort_at, input int stop_at);
        @(negedge clk);
        #2;
        sclk_edge(1'b0, 1'($urandom));
        sclk_edge(1'b0, 1'($urandom));
        sclk_edge(1'b1, 1'($urandom));
        if (abort_at > 0) begin
            for (int k = 0; k < abort_at; k++) sclk_edge(1'b0, 1'($urandom));
            sclk_edge(1'b1, 1'($urandom));
        end
        for (int i = 15; i >= 0; i--) begin
            if (stop_at > 0 && (15 - i) == stop_at) begin
                SDOFS = 1'b0;
                SDO   = 1'b0;
                return;
            end
            SDOFS = 1'b0;
            SDO   = w[i];
            #61 SCLK = 1'b1;
            if (i == 0) begin
                q.push_back('{data: w, cnt: clk_n});
                last_bit0_cnt = clk_n;
            end
            #61 SCLK = 1'b0;
        end
        SDO = 1'b0;
    endtask

    task automatic pulse_sync();
        @(negedge clk);
        SYNC = 1'b1;
        @(negedge clk);
        SYNC = 1'b0;
        chk("SE_after_sync", 32'(SE), 1);
    endtask

    task automatic wait_valid(output logic [15:0] d, output logic [2:0] ix, output logic fd);
        bit got = 1'b0;
        d  = '0;
        ix = '0;
        fd = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            @(negedge clk);
            if (ch_valid) begin
                got = 1'b1;
                d   = ch_data;
                ix  = ch_idx;
                fd  = frame_done;
            end
        end
        chk("valid_seen", 32'(got), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic [2:0]  ix;
        logic        fd;
        logic [15:0] w;
        rst_l = 1'b0;
        SYNC  = 1'b0;
        SCLK  = 1'b0;
        SDOFS = 1'b0;
        SDO   = 1'b0;
        repeat (3) @(negedge clk);
        rst_l = 1'b1;
        repeat (2) @(negedge clk);
        chk("SE_before_sync", 32'(SE), 0);

        // Enable.
        pulse_sync();

        // Single word.
        send_word(16'h7FFF, 0, 0);
        wait_valid(d, ix, fd);
        chk("single_data", 32'(d), 32'h7FFF);
        chk("single_idx", 32'(ix), 0);
        chk("single_fd", 32'(fd), 0);
        @(negedge clk);
        chk("single_pulse_width", 32'(ch_valid), 0);

        // Full frame plus wrap.
        pulse_sync();
        for (int k = 1; k <= 6; k++) begin
            send_word(16'(k), 0, 0);
            wait_valid(d, ix, fd);
            chk("frame_idx", 32'(ix), 32'(k - 1));
            chk("frame_fd", 32'(fd), 32'(k == 6));
        end
        send_word(16'h8000, 0, 0);
        wait_valid(d, ix, fd);
        chk("wrap_data", 32'(d), 32'h8000);
        chk("wrap_idx", 32'(ix), 0);

        // SYNC realign between words.
        send_word(16'h0101, 0, 0);
        wait_valid(d, ix, fd);
        send_word(16'h0202, 0, 0);
        wait_valid(d, ix, fd);
        chk("pre_sync_idx", 32'(ix), 2);
        pulse_sync();
        send_word(16'h1234, 0, 0);
        wait_valid(d, ix, fd);
        chk("realign_data", 32'(d), 32'h1234);
        chk("realign_idx", 32'(ix), 0);

        // SYNC on the very edge that delivers a word.
        send_word(16'h5555, 0, 0);
        for (int g = 0; g < 20 && clk_n < last_bit0_cnt + 2; g++) @(negedge clk);
        SYNC = 1'b1;
        @(negedge clk);
        SYNC = 1'b0;
        chk("coinc_valid", 32'(ch_valid), 1);
        chk("coinc_idx", 32'(ch_idx), 1);
        send_word(16'h6666, 0, 0);
        wait_valid(d, ix, fd);
        chk("after_coinc_idx", 32'(ix), 0);

        // Aborted frame.
        send_word(16'hA5A5, 8, 0);
        wait_valid(d, ix, fd);
        chk("abort_data", 32'(d), 32'hA5A5);
        repeat (6) @(negedge clk);

        // Reset in the middle of a word.
        send_word(16'hFFFF, 0, 7);
        @(negedge clk);
        #5 rst_l = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_SE", 32'(SE), 0);
        #5 rst_l = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_SE", 32'(SE), 0);
        pulse_sync();
        send_word(16'hBEEF, 0, 0);
        wait_valid(d, ix, fd);
        chk("post_rst_data", 32'(d), 32'hBEEF);
        chk("post_rst_idx", 32'(ix), 0);

        // Randomised traffic against the model.
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            w = 16'($urandom);
            if (r == 0) pulse_sync();
            if (r == 1) send_word(w, int'($urandom_range(1, 15)), 0);
            else send_word(w, 0, 0);
            if (r == 2) begin
                // SYNC pulse at a random point while the word is in flight.
                repeat (int'($urandom_range(0, 4))) @(negedge clk);
                pulse_sync();
            end
            repeat (int'($urandom_range(0, 4))) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
